sp_unit: RTL and testbench

Parametrised stack-pointer unit for the CPU datapath: holds the stack pointer and applies push/pop decrement/increment, direct load, and single-level shadow save/restore for interrupt entry/exit. It optionally enforces configured stack bounds, with sticky overflow/underflow flags and a fault state. It replaces the plain load-only SP register and feeds the memory address mux and the ALU operand path.

---
 rtl/sp_unit.sv | 93 +++++++++
 tb/tb_sp_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/sp_unit.sv
// sp_unit: stack pointer with push/pop, load, shadow save/restore and optional bounds faulting.
// Bounds checking, OVF/UNF and the RUN/FAULT machine exist only when SP_BOUNDS_CHECK_EN is defined.
module sp_unit #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = 16'hF3FF,
    parameter int unsigned      STEP      = 1,
    parameter logic [WIDTH-1:0] LIMIT_LO  = 16'hF000,
    parameter logic [WIDTH-1:0] LIMIT_HI  = 16'hF3FF
) (
    input  logic             CLK,
    input  logic             PRESET,
    input  logic             CE,
    input  logic             PUSH,
    input  logic             POP,
    input  logic             LOAD,
    input  logic             SAVE,
    input  logic             RESTORE,
    input  logic             CLRERR,
    input  logic [WIDTH-1:0] newSP,
    output logic [WIDTH-1:0] SP,
    output logic             OVF,
    output logic             UNF,
    output logic             FAULT
);
    localparam logic [WIDTH-1:0] step = WIDTH'(STEP);
    logic [WIDTH-1:0] sp, shadow, sp_nxt;
    logic push_ok, pop_ok, mv_ok;
    logic do_push, do_pop;
    assign do_push = PUSH & ~POP & ~LOAD & ~RESTORE;
    assign do_pop  = POP & ~PUSH & ~LOAD & ~RESTORE;
`ifdef SP_BOUNDS_CHECK_EN
    typedef enum logic {RUN, FLT} state_t;
    state_t state;
    logic ovf, unf;
    logic [WIDTH:0] lo_min, sum;
    // Widened compares so a borrow/carry out of the pointer never looks legal
    always_comb begin
        lo_min  = {1'b0, LIMIT_LO} + {1'b0, step};
        sum     = {1'b0, sp} + {1'b0, step};
        push_ok = ({1'b0, sp} >= lo_min) && (sp >= step);
        pop_ok  = !sum[WIDTH] && (sum[WIDTH-1:0] <= LIMIT_HI);
        mv_ok   = (state == RUN) && !CLRERR;
    end
    always_ff @(posedge CLK) begin
        if (PRESET) begin
            ovf   <= 1'b0;
            unf   <= 1'b0;
            state <= RUN;
        end else if (CLRERR) begin
            ovf   <= 1'b0;
            unf   <= 1'b0;
            state <= RUN;
        end else if (CE && state == RUN) begin
            if (do_push && !push_ok) begin
                ovf   <= 1'b1;
                state <= FLT;
            end
            if (do_pop && !pop_ok) begin
                unf   <= 1'b1;
                state <= FLT;
            end
        end
    end
    assign OVF   = ovf;
    assign UNF   = unf;
    assign FAULT = (state == FLT);
`else
    logic unused;
    assign unused  = ^{LIMIT_LO, LIMIT_HI, CLRERR};
    assign push_ok = 1'b1;
    assign pop_ok  = 1'b1;
    assign mv_ok   = 1'b1;
    assign OVF     = 1'b0;
    assign UNF     = 1'b0;
    assign FAULT   = 1'b0;
`endif
    always_comb begin
        sp_nxt = RESTORE ? shadow :
                 LOAD ? newSP :
                 (do_push && push_ok && mv_ok) ? sp - step :
                 (do_pop && pop_ok && mv_ok) ? sp + step : sp;
    end
    always_ff @(posedge CLK) begin
        if (PRESET) begin
            sp     <= RESET_VAL;
            shadow <= RESET_VAL;
        end else if (CE) begin
            sp <= sp_nxt;
            if (SAVE) shadow <= sp;
        end
    end
    assign SP = sp;
endmodule

// File: tb/tb_sp_unit.sv
// tb_sp_unit: directed checks of sp_unit; bounds cases run when SP_BOUNDS_CHECK_EN is defined.
module tb_sp_unit;
    logic clk = 1'b0;
    logic preset, ce, push, pop, load, save, restore, clrerr;
    logic [15:0] new_sp, sp;
    logic ovf, unf, fault;
    int checks = 0, failures = 0;
    localparam logic [6:0] k_ce = 7'b1000000, k_push = 7'b0100000, k_pop = 7'b0010000,
                           k_load = 7'b0001000, k_save = 7'b0000100, k_rest = 7'b0000010,
                           k_clr = 7'b0000001;
    sp_unit dut (
        .CLK(clk), .PRESET(preset), .CE(ce), .PUSH(push), .POP(pop), .LOAD(load),
        .SAVE(save), .RESTORE(restore), .CLRERR(clrerr), .newSP(new_sp),
        .SP(sp), .OVF(ovf), .UNF(unf), .FAULT(fault)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic rst, input logic [6:0] c, input logic [15:0] v);
        preset = rst;
        {ce, push, pop, load, save, restore, clrerr} = c;
        new_sp = v;
        @(posedge clk);
        #1;
        preset = 1'b0;
        {ce, push, pop, load, save, restore, clrerr} = '0;
    endtask
    initial begin
        cyc(1'b1, '0, 16'h0);
        chk("rst_sp", sp, 16'hF3FF);
        chk("rst_ovf", 16'(ovf), 16'h0);
        chk("rst_unf", 16'(unf), 16'h0);
        chk("rst_fault", 16'(fault), 16'h0);
        cyc(1'b0, k_ce | k_push, 16'h0); chk("push1", sp, 16'hF3FE);
        cyc(1'b0, k_ce | k_push, 16'h0); chk("push2", sp, 16'hF3FD);
        cyc(1'b0, k_ce | k_push, 16'h0); chk("push3", sp, 16'hF3FC);
        cyc(1'b0, k_ce | k_pop, 16'h0);  chk("pop1", sp, 16'hF3FD);
        cyc(1'b0, k_ce | k_load, 16'hF200); chk("load", sp, 16'hF200);
        cyc(1'b0, k_ce | k_save | k_push, 16'h0); chk("save_push", sp, 16'hF1FF);
        cyc(1'b0, k_ce | k_rest, 16'h0); chk("restore", sp, 16'hF200);
        cyc(1'b0, k_ce | k_rest | k_load, 16'hF000); chk("rest_over_load", sp, 16'hF200);
        cyc(1'b0, k_push, 16'h0); chk("ce0_push", sp, 16'hF200);
        cyc(1'b0, k_pop, 16'h0);  chk("ce0_pop", sp, 16'hF200);
        cyc(1'b0, k_load, 16'h1111); chk("ce0_load", sp, 16'hF200);
        cyc(1'b0, k_save, 16'h0);
        cyc(1'b0, k_ce | k_load, 16'hF100);
        cyc(1'b0, k_ce | k_rest, 16'h0); chk("ce0_save_held", sp, 16'hF200);
        cyc(1'b0, k_ce | k_push | k_pop, 16'h0); chk("push_pop", sp, 16'hF200);
        cyc(1'b1, k_ce | k_load, 16'h1234); chk("preset_load", sp, 16'hF3FF);
        cyc(1'b0, k_ce | k_rest, 16'h0); chk("preset_shadow", sp, 16'hF3FF);
`ifdef SP_BOUNDS_CHECK_EN
        cyc(1'b0, k_ce | k_load, 16'hF000);
        cyc(1'b0, k_ce | k_push, 16'h0);
        chk("ovf_sp", sp, 16'hF000);
        chk("ovf_flag", 16'(ovf), 16'h1);
        chk("ovf_fault", 16'(fault), 16'h1);
        cyc(1'b0, k_ce | k_push, 16'h0); chk("fault_push", sp, 16'hF000);
        cyc(1'b0, k_clr, 16'h0);
        chk("clr_ovf", 16'(ovf), 16'h0);
        chk("clr_fault", 16'(fault), 16'h0);
        cyc(1'b0, k_ce | k_push, 16'h0);
        chk("ovf2_sp", sp, 16'hF000);
        chk("ovf2_flag", 16'(ovf), 16'h1);
        cyc(1'b1, '0, 16'h0);
        cyc(1'b0, k_ce | k_pop, 16'h0);
        chk("unf_sp", sp, 16'hF3FF);
        chk("unf_flag", 16'(unf), 16'h1);
        chk("unf_fault", 16'(fault), 16'h1);
        cyc(1'b0, k_ce | k_load, 16'hF100);
        chk("fault_load", sp, 16'hF100);
        chk("fault_stays", 16'(fault), 16'h1);
        cyc(1'b0, k_clr | k_ce | k_pop, 16'h0);
        chk("clr_pop_ignored", sp, 16'hF100);
        chk("clr_unf", 16'(unf), 16'h0);
        cyc(1'b0, k_ce | k_load, 16'hF001);
        cyc(1'b0, k_ce | k_push, 16'h0);
        chk("push_to_lo", sp, 16'hF000);
        chk("push_to_lo_ovf", 16'(ovf), 16'h0);
`else
        cyc(1'b0, k_ce | k_load, 16'h0000);
        cyc(1'b0, k_ce | k_push, 16'h0); chk("wrap_push", sp, 16'hFFFF);
        cyc(1'b0, k_ce | k_pop, 16'h0);  chk("wrap_pop", sp, 16'h0000);
        chk("nochk_ovf", 16'(ovf), 16'h0);
        chk("nochk_unf", 16'(unf), 16'h0);
        cyc(1'b0, k_ce | k_load, 16'hF3FF);
        cyc(1'b0, k_ce | k_pop, 16'h0);  chk("nochk_pop_hi", sp, 16'hF400);
        chk("nochk_fault", 16'(fault), 16'h0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
